// File: rtl/gpu_sched_pkg.sv
// Shared types and sizes for the GPU task scheduler: core/slot counts and FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package gpu_sched_pkg;

    localparam int CORE_NUM = 16;
    localparam int SLOT_NUM = 4;                 // power of two so the round-robin index wraps for free
    localparam int SLOT_W   = $clog2(SLOT_NUM);

    typedef logic [CORE_NUM-1:0] core_mask_t;

    // IDLE: allocatable; LAUNCH: claimed, core not yet busy; RUN: core busy
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } core_state_e;

    typedef enum logic {
        ARB   = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    // Result of a round-robin search over a slot request vector
    typedef struct packed {
        logic              found;
        logic [SLOT_W-1:0] idx;
    } slot_sel_t;

endpackage

// File: rtl/core_mask_arbiter_if.sv
// Bundle between the task-header slots / cores / frame loader and the core mask arbiter.
// Latency: n/a (wiring only).
// Backpressure: grant_valid/grant_ready handshake toward the frame loader; slots held until slot_ack.
// Ports: slot_* (decoded headers in, ack out), core_ready in, grant_* (offer to loader),
//        core_start / free_mask / err_zero_mask out.
interface core_mask_arbiter_if;
    import gpu_sched_pkg::*;

    logic [SLOT_NUM-1:0]          slot_valid;
    logic [SLOT_NUM*CORE_NUM-1:0] slot_mask;
    logic [SLOT_NUM-1:0]          slot_barrier;
    logic [SLOT_NUM-1:0]          slot_ack;
    logic [CORE_NUM-1:0]          core_ready;
    logic                         grant_valid;
    logic                         grant_ready;
    logic [SLOT_W-1:0]            grant_slot;
    logic [CORE_NUM-1:0]          grant_mask;
    logic [CORE_NUM-1:0]          core_start;
    logic [CORE_NUM-1:0]          free_mask;
    logic                         err_zero_mask;

    // Environment side: header slots, cores and frame loader
    modport master (
        output slot_valid, slot_mask, slot_barrier, core_ready, grant_ready,
        input  slot_ack, grant_valid, grant_slot, grant_mask, core_start, free_mask, err_zero_mask
    );

    // Arbiter side
    modport slave (
        input  slot_valid, slot_mask, slot_barrier, core_ready, grant_ready,
        output slot_ack, grant_valid, grant_slot, grant_mask, core_start, free_mask, err_zero_mask
    );

endinterface

// File: rtl/core_tracker.sv
// Per-core claim/run tracker: IDLE -> LAUNCH on claim, LAUNCH -> RUN when core drops ready, RUN -> IDLE on ready.
// Latency: state changes one cycle after the triggering input; o_free is combinational on core_ready.
// Backpressure: none; a claim outside IDLE is ignored.
// Ports: clk, reset (sync, active-high), i_claim, i_core_ready in; o_state, o_free out.
module core_tracker
    import gpu_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_claim,
    input  logic        i_core_ready,
    output core_state_e o_state,
    output logic        o_free
);

    core_state_e r_state;
    core_state_e w_state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_claim)       w_state_nxt = LAUNCH;
            LAUNCH:  if (!i_core_ready) w_state_nxt = RUN;
            RUN:     if (i_core_ready)  w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    assign o_state = r_state;
    // A LAUNCH core still shows ready=1 but is already owned, so only IDLE counts as free
    assign o_free  = (r_state == IDLE) && i_core_ready;

endmodule

// File: rtl/core_mask_arbiter.sv
// Grants pending task-header slots whose whole core mask is free, round-robin, and tracks core claims.
// Latency: eligible in cycle N -> grant_valid in N+1; accept in M -> slot_ack/core_start in M+1.
// Backpressure: grant held stable while grant_ready is low; slots are not re-evaluated during the offer.
// Ports: clk, reset (sync, active-high), bus (core_mask_arbiter_if.slave: slots, cores, grant, status).
module core_mask_arbiter
    import gpu_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    core_mask_arbiter_if.slave bus
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [SLOT_W-1:0]   r_rr_ptr;
    logic [SLOT_W-1:0]   r_grant_slot;
    core_mask_t          r_grant_mask;
    core_mask_t          r_core_start;
    logic [SLOT_NUM-1:0] r_ack;

    core_mask_t          w_free;
    core_mask_t          w_claim;
    core_state_e         w_core_state [CORE_NUM];
    core_mask_t          w_mask       [SLOT_NUM];
    logic [SLOT_NUM-1:0] w_live;
    logic [SLOT_NUM-1:0] w_fits;
    logic [SLOT_NUM-1:0] w_zero;
    logic [SLOT_NUM-1:0] w_bar_req;
    logic [SLOT_NUM-1:0] w_elig;
    logic                w_all_free;
    logic                w_accept;
    logic                w_in_arb;
    logic                w_drop;
    logic                w_load;
    slot_sel_t           w_pick;
    slot_sel_t           w_zero_sel;

    // First set bit of req at or after ptr, wrapping. Scanning from the far end lets the
    // nearest candidate overwrite the others.
    function automatic slot_sel_t rr_pick(input logic [SLOT_NUM-1:0] req, input logic [SLOT_W-1:0] ptr);
        slot_sel_t         sel;
        logic [SLOT_W-1:0] idx;
        sel = '0;
        for (int k = SLOT_NUM - 1; k >= 0; k--) begin
            idx = ptr + SLOT_W'(k);
            if (req[idx]) begin
                sel.found = 1'b1;
                sel.idx   = idx;
            end
        end
        return sel;
    endfunction

    assign w_accept = (r_state == OFFER) && bus.grant_ready;

    // Per-core trackers; a claim lands only on cores named by the accepted grant
    for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
        assign w_claim[c] = w_accept && r_grant_mask[c] && (w_core_state[c] == IDLE);
        core_tracker u_trk (
            .clk          (clk),
            .reset        (reset),
            .i_claim      (w_claim[c]),
            .i_core_ready (bus.core_ready[c]),
            .o_state      (w_core_state[c]),
            .o_free       (w_free[c])
        );
    end

    // A slot acked this cycle is still presented by upstream until the edge; hide it so it
    // cannot be picked twice or hold the barrier drain open.
    assign w_live = bus.slot_valid & ~r_ack;

    for (genvar i = 0; i < SLOT_NUM; i++) begin : g_slot
        assign w_mask[i] = bus.slot_mask[i*CORE_NUM +: CORE_NUM];
        assign w_fits[i] = (w_mask[i] != '0) && ((w_mask[i] & ~w_free) == '0);
        assign w_zero[i] = w_live[i] && (w_mask[i] == '0);
    end

    assign w_all_free = &w_free;
    assign w_bar_req  = w_live & bus.slot_barrier;

    // While any barrier slot is pending only barrier slots compete, and they need every core free
    always_comb begin
        w_elig = '0;
        if (|w_bar_req) begin
            w_elig = w_all_free ? (w_bar_req & w_fits) : '0;
        end else begin
            w_elig = w_live & w_fits;
        end
    end

    assign w_pick     = rr_pick(w_elig, r_rr_ptr);
    assign w_zero_sel = rr_pick(w_zero, r_rr_ptr);

    // Zero-mask drops win over grants in the same ARB cycle; the drop ack is combinational so
    // upstream pops the slot at this edge.
    assign w_in_arb = (r_state == ARB) && !reset;
    assign w_drop   = w_in_arb && w_zero_sel.found;
    assign w_load   = w_in_arb && !w_zero_sel.found && w_pick.found;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB:     if (w_load)          w_state_nxt = OFFER;
            OFFER:   if (bus.grant_ready) w_state_nxt = ARB;
            default:                      w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_rr_ptr     <= '0;
            r_grant_slot <= '0;
            r_grant_mask <= '0;
            r_core_start <= '0;
            r_ack        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_start <= '0;
            r_ack        <= '0;
            if (w_load) begin
                r_grant_slot <= w_pick.idx;
                r_grant_mask <= w_mask[w_pick.idx];
            end
            if (w_accept) begin
                r_core_start <= r_grant_mask;
                r_ack        <= SLOT_NUM'(1) << r_grant_slot;
                r_rr_ptr     <= r_grant_slot + 1'b1;
            end
        end
    end

    assign bus.grant_valid   = (r_state == OFFER);
    assign bus.grant_slot    = r_grant_slot;
    assign bus.grant_mask    = r_grant_mask;
    assign bus.core_start    = r_core_start;
    assign bus.free_mask     = w_free;
    assign bus.err_zero_mask = w_drop;
    assign bus.slot_ack      = r_ack | (w_drop ? (SLOT_NUM'(1) << w_zero_sel.idx) : '0);

endmodule

// File: tb/tb_core_mask_arbiter.sv
// Self-checking bench for core_mask_arbiter: expected grants queued at stimulus time, popped on offer.
// Latency: n/a.
// Backpressure: bench drives grant_ready per scenario and pops slots when acked.
module tb_core_mask_arbiter;
    import gpu_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_mask_arbiter_if ifc();

    core_mask_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [1:0]  slot;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        o_gv;
    logic [1:0]  o_gs;
    logic [15:0] o_gm;
    logic [15:0] o_cs;
    logic [15:0] o_free;
    logic [3:0]  o_ack;
    logic        o_err;

    // Sample outputs mid-cycle, then behave like upstream: pop whatever was acked
    task automatic step();
        @(negedge clk);
        o_gv   = ifc.grant_valid;
        o_gs   = ifc.grant_slot;
        o_gm   = ifc.grant_mask;
        o_cs   = ifc.core_start;
        o_free = ifc.free_mask;
        o_ack  = ifc.slot_ack;
        o_err  = ifc.err_zero_mask;
        ifc.slot_valid = ifc.slot_valid & ~o_ack;
    endtask

    task automatic set_slot(input int i, input logic [15:0] m, input logic b);
        ifc.slot_mask[i*16 +: 16] = m;
        ifc.slot_barrier[i]       = b;
        ifc.slot_valid[i]         = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            lat = k + 1;
            if (o_gv) seen = 1'b1;
        end
    endtask

    // Cores in mask go busy then return to ready, walking trackers back to IDLE
    task automatic run_and_finish(input logic [15:0] m);
        ifc.core_ready = ifc.core_ready & ~m;
        step(); step();
        ifc.core_ready = ifc.core_ready | m;
        step(); step();
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        ifc.slot_valid   = '0;
        ifc.slot_mask    = '0;
        ifc.slot_barrier = '0;
        ifc.core_ready   = 16'hffff;
        ifc.grant_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        n_tests++;
        if ({o_gv, o_gs, o_gm, o_cs, o_ack, o_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gv=%0b gs=%0d gm=%h cs=%h ack=%b err=%0b, want all 0", o_gv, o_gs, o_gm, o_cs, o_ack, o_err);
        end
        n_tests++;
        if (o_free !== 16'hffff) begin
            n_fail++;
            $display("FAIL reset_free: free=%h, want ffff", o_free);
        end
    endtask

    task automatic test_basic();
        bit   seen;
        int   lat;
        exp_t e;
        ifc.grant_ready = 1'b1;
        set_slot(0, 16'h000f, 1'b0);
        exp_q.push_back('{slot: 2'd0, mask: 16'h000f});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || lat != 1 || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL basic_grant: seen=%0b lat=%0d slot=%0d mask=%h, want lat=1 slot=%0d mask=%h", seen, lat, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        n_tests++;
        if (o_gv !== 1'b0 || o_cs !== 16'h000f || o_ack !== 4'b0001 || o_free !== 16'hfff0) begin
            n_fail++;
            $display("FAIL basic_start: gv=%0b cs=%h ack=%b free=%h, want 0 000f 0001 fff0", o_gv, o_cs, o_ack, o_free);
        end
        ifc.core_ready[3:0] = 4'h0;
        step(); step();
        n_tests++;
        if (o_free !== 16'hfff0) begin
            n_fail++;
            $display("FAIL basic_run_free: free=%h, want fff0", o_free);
        end
        ifc.core_ready[3:0] = 4'hf;
        #1;
        n_tests++;
        if (ifc.free_mask !== 16'hfff0) begin
            n_fail++;
            $display("FAIL basic_finish_same_cycle: free=%h, want fff0", ifc.free_mask);
        end
        step();
        n_tests++;
        if (o_free !== 16'hffff) begin
            n_fail++;
            $display("FAIL basic_finish_next: free=%h, want ffff", o_free);
        end
    endtask

    task automatic test_parallel();
        bit   seen;
        int   lat;
        int   early;
        exp_t e;
        ifc.grant_ready = 1'b1;
        set_slot(0, 16'h000f, 1'b0);
        exp_q.push_back('{slot: 2'd0, mask: 16'h000f});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL par_first: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        ifc.core_ready[3:0] = 4'h0;
        step();
        set_slot(1, 16'h00f0, 1'b0);
        set_slot(2, 16'h00f0, 1'b0);
        exp_q.push_back('{slot: 2'd1, mask: 16'h00f0});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || lat != 1 || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL par_slot1: seen=%0b lat=%0d slot=%0d mask=%h, want lat=1 slot=%0d mask=%h", seen, lat, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        early = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_gv) early++;
        end
        ifc.core_ready[7:4] = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_gv) early++;
        end
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL par_slot2_wait: grant_valid cycles=%0d, want 0", early);
        end
        ifc.core_ready[7:4] = 4'hf;
        exp_q.push_back('{slot: 2'd2, mask: 16'h00f0});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL par_slot2: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        run_and_finish(16'h00f0);
    endtask

    task automatic test_barrier();
        bit   seen;
        int   lat;
        int   early;
        exp_t e;
        ifc.grant_ready = 1'b1;
        set_slot(0, 16'h0f00, 1'b1);
        set_slot(3, 16'h00f0, 1'b0);
        early = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_gv) early++;
        end
        n_tests++;
        if (early != 0 || o_free !== 16'hfff0) begin
            n_fail++;
            $display("FAIL bar_blocked: grant_valid cycles=%0d free=%h, want 0 fff0", early, o_free);
        end
        ifc.core_ready[3:0] = 4'hf;
        exp_q.push_back('{slot: 2'd0, mask: 16'h0f00});
        exp_q.push_back('{slot: 2'd3, mask: 16'h00f0});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL bar_first: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || lat != 2 || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL bar_second: seen=%0b lat=%0d slot=%0d mask=%h, want lat=2 slot=%0d mask=%h", seen, lat, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        run_and_finish(16'h0ff0);
    endtask

    task automatic test_zero_mask();
        int bad;
        ifc.grant_ready = 1'b1;
        set_slot(1, 16'h0000, 1'b0);
        step();
        n_tests++;
        if (o_ack !== 4'b0010 || o_err !== 1'b1 || o_gv !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_drop: ack=%b err=%0b gv=%0b, want 0010 1 0", o_ack, o_err, o_gv);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_gv || o_err || o_cs != 16'h0 || o_ack != 4'h0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL zero_after: bad cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_backpressure();
        bit   seen;
        int   lat;
        exp_t e;
        ifc.grant_ready = 1'b0;
        set_slot(2, 16'h0003, 1'b0);
        exp_q.push_back('{slot: 2'd2, mask: 16'h0003});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL bp_offer: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (o_gv !== 1'b1 || o_gs !== e.slot || o_gm !== e.mask || o_cs !== 16'h0 || o_ack !== 4'h0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: gv=%0b slot=%0d mask=%h cs=%h ack=%b, want 1 %0d %h 0000 0", k, o_gv, o_gs, o_gm, o_cs, o_ack, e.slot, e.mask);
            end
        end
        ifc.grant_ready = 1'b1;
        step();
        n_tests++;
        if (o_gv !== 1'b0 || o_cs !== 16'h0003 || o_ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_accept: gv=%0b cs=%h ack=%b, want 0 0003 0100", o_gv, o_cs, o_ack);
        end
        run_and_finish(16'h0003);
    endtask

    task automatic test_reset_mid();
        bit   seen;
        int   lat;
        exp_t e;
        ifc.grant_ready = 1'b1;
        set_slot(0, 16'h00f0, 1'b0);
        exp_q.push_back('{slot: 2'd0, mask: 16'h00f0});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL rst_setup: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        step();
        ifc.core_ready[7:4] = 4'h0;
        step(); step();
        ifc.grant_ready = 1'b0;
        set_slot(1, 16'h000f, 1'b0);
        exp_q.push_back('{slot: 2'd1, mask: 16'h000f});
        wait_grant(10, seen, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
            n_fail++;
            $display("FAIL rst_offer: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", seen, o_gs, o_gm, e.slot, e.mask);
        end
        reset = 1'b1;
        step();
        n_tests++;
        if ({o_gv, o_gs, o_gm, o_cs, o_ack, o_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: gv=%0b gs=%0d gm=%h cs=%h ack=%b err=%0b, want all 0", o_gv, o_gs, o_gm, o_cs, o_ack, o_err);
        end
        reset          = 1'b0;
        ifc.slot_valid = '0;
        step();
        n_tests++;
        if (o_free !== 16'hff0f || o_gv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_free: free=%h gv=%0b, want ff0f 0", o_free, o_gv);
        end
        ifc.grant_ready = 1'b1;
        set_slot(0, 16'h0001, 1'b0);
        set_slot(1, 16'h0002, 1'b0);
        exp_q.push_back('{slot: 2'd0, mask: 16'h0001});
        exp_q.push_back('{slot: 2'd1, mask: 16'h0002});
        for (int g = 0; g < 2; g++) begin
            wait_grant(10, seen, lat);
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || o_gs !== e.slot || o_gm !== e.mask) begin
                n_fail++;
                $display("FAIL rst_rr%0d: seen=%0b slot=%0d mask=%h, want slot=%0d mask=%h", g, seen, o_gs, o_gm, e.slot, e.mask);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parallel();
        test_barrier();
        test_zero_mask();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
